// File: rtl/sfx_engine.sv
// rtl/sfx_engine.sv - prioritized stepped square-wave sound-effect engine
//
// Purpose: edge-detects NUM_SFX game event levels, picks the highest-index
// request, and plays that effect as NUM_NOTES square-wave notes of
// NOTE_CYCLES clocks each, with the half-period stepping by SFX_STEP per note.
//
// Ports:
//   CLK100MHZ  in   system clock, rising edge
//   reset      in   synchronous, active-high
//   trigger    in   [NUM_SFX] event levels, rising edge requests effect i
//   mute       in   forces audio low, sequencing continues
//   audio      out  registered square-wave output
//   busy       out  high while an effect plays
//   active_id  out  [ID_W] index of playing effect, 0 when idle
//   done       out  one-cycle pulse on natural completion
module sfx_engine #(
   parameter int NUM_SFX     = 4,
   parameter int DIV_W       = 20,
   parameter int NUM_NOTES   = 8,
   parameter int NOTE_CYCLES = 5_000_000,
   parameter logic [NUM_SFX*DIV_W-1:0] SFX_START = {NUM_SFX{DIV_W'(50_000)}},
   parameter logic [NUM_SFX*DIV_W-1:0] SFX_STEP  = '0,
   localparam int ID_W = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1
) (
   input  logic               CLK100MHZ,
   input  logic               reset,
   input  logic [NUM_SFX-1:0] trigger,
   input  logic               mute,
   output logic               audio,
   output logic               busy,
   output logic [ID_W-1:0]    active_id,
   output logic               done
);

   localparam int SW     = DIV_W + 9;
   localparam int DUR_W  = $clog2(NOTE_CYCLES);
   localparam int NOTE_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
   localparam logic [DUR_W-1:0]  DUR_LAST  = DUR_W'(NOTE_CYCLES - 1);
   localparam logic [NOTE_W-1:0] NOTE_LAST = NOTE_W'(NUM_NOTES - 1);
   localparam logic signed [SW-1:0] HP_MIN = SW'(2);
   localparam logic signed [SW-1:0] HP_MAX = {9'b0, {DIV_W{1'b1}}};

   typedef enum logic {S_IDLE, S_PLAY} state_t;

   state_t              state_q, state_d;
   logic [NUM_SFX-1:0]  trig_q, trig_d;
   logic [ID_W-1:0]     active_id_q, active_id_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [DUR_W-1:0]    dur_q, dur_d;
   logic [DIV_W-1:0]    tone_q, tone_d;
   logic [DIV_W-1:0]    hp_q, hp_d;
   logic                raw_q, raw_d;
   logic                audio_q, audio_d;
   logic                done_q, done_d;

   logic [NUM_SFX-1:0]  req;
   logic [ID_W-1:0]     win;
   logic                start;
   logic [DIV_W-1:0]    start_hp;
   logic [DIV_W-1:0]    next_hp;
   logic [DIV_W-1:0]    step_raw;

   function automatic logic [DIV_W-1:0] clamp_hp(input logic signed [SW-1:0] v);
      if (v < HP_MIN) return DIV_W'(2);
      else if (v > HP_MAX) return {DIV_W{1'b1}};
      else return v[DIV_W-1:0];
   endfunction

   // Highest set request bit wins; a lower-index request during play is dropped.
   always_comb begin
      req = trigger & ~trig_q;
      win = '0;
      for (int i = 0; i < NUM_SFX; i++) begin
         if (req[i]) win = ID_W'(i);
      end
      start = (|req) && ((state_q == S_IDLE) || (win >= active_id_q));
   end

   // Start value is unsigned; step is signed. Next note is computed from the
   // current (already clamped) half-period.
   always_comb begin
      start_hp = clamp_hp($signed({9'b0, SFX_START[win*DIV_W +: DIV_W]}));
      step_raw = SFX_STEP[active_id_q*DIV_W +: DIV_W];
      next_hp  = clamp_hp($signed({9'b0, hp_q}) + $signed({{9{step_raw[DIV_W-1]}}, step_raw}));
   end

   always_comb begin
      trig_d      = trigger;
      state_d     = state_q;
      active_id_d = active_id_q;
      note_d      = note_q;
      dur_d       = dur_q;
      tone_d      = tone_q;
      hp_d        = hp_q;
      raw_d       = raw_q;
      done_d      = 1'b0;
      audio_d     = raw_q & ~mute;

      if (start) begin
         // A new request beats a natural completion in the same cycle.
         state_d     = S_PLAY;
         active_id_d = win;
         note_d      = '0;
         dur_d       = '0;
         tone_d      = '0;
         hp_d        = start_hp;
         raw_d       = 1'b0;
      end else if (state_q == S_PLAY) begin
         if (dur_q == DUR_LAST) begin
            if (note_q < NOTE_LAST) begin
               // Note boundary: restart tone phase count, keep output level.
               note_d = note_q + NOTE_W'(1);
               dur_d  = '0;
               tone_d = '0;
               hp_d   = next_hp;
            end else begin
               state_d     = S_IDLE;
               active_id_d = '0;
               note_d      = '0;
               dur_d       = '0;
               tone_d      = '0;
               raw_d       = 1'b0;
               done_d      = 1'b1;
            end
         end else begin
            dur_d = dur_q + DUR_W'(1);
            if (tone_q == hp_q - DIV_W'(1)) begin
               tone_d = '0;
               raw_d  = ~raw_q;
            end else begin
               tone_d = tone_q + DIV_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         // Load current levels so a trigger held through reset does not fire.
         trig_q      <= trigger;
         state_q     <= S_IDLE;
         active_id_q <= '0;
         note_q      <= '0;
         dur_q       <= '0;
         tone_q      <= '0;
         hp_q        <= '0;
         raw_q       <= 1'b0;
         audio_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         trig_q      <= trig_d;
         state_q     <= state_d;
         active_id_q <= active_id_d;
         note_q      <= note_d;
         dur_q       <= dur_d;
         tone_q      <= tone_d;
         hp_q        <= hp_d;
         raw_q       <= raw_d;
         audio_q     <= audio_d;
         done_q      <= done_d;
      end
   end

   assign audio     = audio_q;
   assign busy      = (state_q == S_PLAY);
   assign active_id = active_id_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sfx_engine.sv
// tb/tb_sfx_engine.sv - randomized self-checking bench for sfx_engine
module tb_sfx_engine;

   localparam int NS = 4;
   localparam int DW = 4;
   localparam int NN = 3;
   localparam int NC = 20;
   localparam logic [NS*DW-1:0] START = {4'd0, 4'd14, 4'd3, 4'd4};
   localparam logic [NS*DW-1:0] STEP  = {4'd3, 4'd5, 4'hE, 4'd2};

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NS-1:0] trigger = '0;
   logic          mute = 1'b0;
   logic          audio;
   logic          busy;
   logic [1:0]    active_id;
   logic          done;

   sfx_engine #(
      .NUM_SFX(NS), .DIV_W(DW), .NUM_NOTES(NN), .NOTE_CYCLES(NC),
      .SFX_START(START), .SFX_STEP(STEP)
   ) dut (
      .CLK100MHZ(clk), .reset(reset), .trigger(trigger), .mute(mute),
      .audio(audio), .busy(busy), .active_id(active_id), .done(done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int busy_cycles = 0;
   int done_pulses = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference: half-period table per effect and note, built from the rules.
   int hp_tab [NS][NN];

   function automatic int clampi(input int v);
      if (v < 2) return 2;
      if (v > (1 << DW) - 1) return (1 << DW) - 1;
      return v;
   endfunction

   task automatic build_table();
      logic [NS*DW-1:0] st_v;
      logic [NS*DW-1:0] sp_v;
      st_v = START;
      sp_v = STEP;
      for (int i = 0; i < NS; i++) begin
         int hp;
         int sv;
         sv = int'($signed(sp_v[i*DW +: DW]));
         hp = clampi(int'(st_v[i*DW +: DW]));
         hp_tab[i][0] = hp;
         for (int k = 1; k < NN; k++) begin
            hp = clampi(hp + sv);
            hp_tab[i][k] = hp;
         end
      end
   endtask

   // Square-wave level el cycles after start: toggles every hp cycles within
   // a note, phase counter restarts at each note boundary, level carries over.
   function automatic logic model_raw(input int id, input int el);
      int k;
      int p;
      logic b;
      k = el / NC;
      p = el % NC;
      b = 1'b0;
      for (int j = 0; j < k; j++) b = b ^ ((((NC - 1) / hp_tab[id][j]) % 2) == 1);
      return b ^ (((p / hp_tab[id][k]) % 2) == 1);
   endfunction

   logic [NS-1:0] m_prev = '0;
   logic          m_play = 1'b0;
   int            m_id = 0;
   int            m_el = 0;
   logic          m_done = 1'b0;
   logic          m_audio = 1'b0;

   always @(posedge clk) begin
      logic [NS-1:0] req;
      logic raw_before;
      int w;
      raw_before = m_play ? model_raw(m_id, m_el) : 1'b0;
      if (reset) begin
         m_prev = trigger;
         m_play = 1'b0;
         m_id = 0;
         m_el = 0;
         m_done = 1'b0;
         m_audio = 1'b0;
      end else begin
         req = trigger & ~m_prev;
         m_prev = trigger;
         m_audio = raw_before & ~mute;
         w = -1;
         for (int i = 0; i < NS; i++) if (req[i]) w = i;
         if (w >= 0 && (!m_play || w >= m_id)) begin
            m_play = 1'b1;
            m_id = w;
            m_el = 0;
            m_done = 1'b0;
         end else if (m_play) begin
            m_el++;
            if (m_el == NN * NC) begin
               m_play = 1'b0;
               m_id = 0;
               m_el = 0;
               m_done = 1'b1;
            end else begin
               m_done = 1'b0;
            end
         end else begin
            m_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("audio", int'(audio), int'(m_audio));
         check("busy", int'(busy), int'(m_play));
         check("active_id", int'(active_id), m_id);
         check("done", int'(done), int'(m_done));
         if (busy) busy_cycles++;
         if (done) done_pulses++;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [NS-1:0] mask);
      trigger = mask;
      @(negedge clk);
      trigger = '0;
   endtask

   task automatic clear_counts();
      busy_cycles = 0;
      done_pulses = 0;
   endtask

   initial begin
      int n;
      build_table();
      check("hp_tab_e0", hp_tab[0][0]*10000 + hp_tab[0][1]*100 + hp_tab[0][2], 40608);
      check("hp_tab_e1", hp_tab[1][0]*10000 + hp_tab[1][1]*100 + hp_tab[1][2], 30202);
      check("hp_tab_e2", hp_tab[2][0]*10000 + hp_tab[2][1]*100 + hp_tab[2][2], 141515);
      check("hp_tab_e3", hp_tab[3][0]*10000 + hp_tab[3][1]*100 + hp_tab[3][2], 20508);

      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_busy", int'(busy), 0);
      check("reset_audio", int'(audio), 0);
      reset = 1'b0;
      wait_cycles(3);

      // Basic play of effect 0 with first-rise timing.
      clear_counts();
      pulse(4'b0001);
      n = 0;
      for (int i = 1; i <= 20 && n == 0; i++) begin
         @(negedge clk);
         if (audio) n = i;
      end
      check("first_rise", n, 5);
      wait_cycles(80);
      check("basic_busy", busy_cycles, 60);
      check("basic_done", done_pulses, 1);

      // Higher priority preempts.
      clear_counts();
      pulse(4'b0001);
      wait_cycles(9);
      pulse(4'b0010);
      wait_cycles(90);
      check("preempt_busy", busy_cycles, 70);
      check("preempt_done", done_pulses, 1);

      // Lower priority dropped.
      clear_counts();
      pulse(4'b0010);
      wait_cycles(9);
      pulse(4'b0001);
      wait_cycles(80);
      check("drop_busy", busy_cycles, 60);
      check("drop_done", done_pulses, 1);

      // Simultaneous requests.
      clear_counts();
      pulse(4'b0011);
      check("simul_id", int'(active_id), 1);
      wait_cycles(80);

      // Same-id retrigger mid-effect.
      clear_counts();
      pulse(4'b0001);
      wait_cycles(29);
      pulse(4'b0001);
      wait_cycles(100);
      check("retrig_busy", busy_cycles, 90);
      check("retrig_done", done_pulses, 1);

      // Retrigger coincident with natural completion.
      clear_counts();
      pulse(4'b0001);
      wait_cycles(59);
      pulse(4'b0001);
      wait_cycles(80);
      check("collide_busy", busy_cycles, 120);
      check("collide_done", done_pulses, 1);

      // Clamp effects.
      pulse(4'b0100);
      wait_cycles(70);
      pulse(4'b1000);
      wait_cycles(70);

      // Mute mid-effect.
      clear_counts();
      pulse(4'b0001);
      wait_cycles(15);
      mute = 1'b1;
      wait_cycles(20);
      mute = 1'b0;
      wait_cycles(40);
      check("mute_busy", busy_cycles, 60);
      check("mute_done", done_pulses, 1);

      // Reset mid-effect with trigger held through release.
      pulse(4'b0001);
      wait_cycles(10);
      reset = 1'b1;
      trigger = 4'b0001;
      wait_cycles(3);
      reset = 1'b0;
      clear_counts();
      wait_cycles(15);
      check("held_no_start", busy_cycles, 0);
      trigger = '0;
      wait_cycles(1);
      clear_counts();
      pulse(4'b0001);
      wait_cycles(80);
      check("after_reset_busy", busy_cycles, 60);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         for (int i = 0; i < NS; i++) if ($urandom_range(0, 29) == 0) trigger[i] = ~trigger[i];
         if ($urandom_range(0, 39) == 0) mute = ~mute;
         reset = ($urandom_range(0, 799) == 0);
      end
      reset = 1'b0;
      wait_cycles(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
